// File: rtl/nec_ir_pkg.sv
// rtl/nec_ir_pkg.sv - NEC IR receiver shared state encoding, nominal timings and window helper
package nec_ir_pkg;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LEAD_MARK  = 3'd1;
    localparam logic [2:0] LEAD_SPACE = 3'd2;
    localparam logic [2:0] BIT_MARK   = 3'd3;
    localparam logic [2:0] BIT_SPACE  = 3'd4;
    localparam logic [2:0] STOP       = 3'd5;
    localparam logic [2:0] STOP_RPT   = 3'd6;

    localparam int NOM_LEAD_MARK_US  = 9000;
    localparam int NOM_LEAD_SPACE_US = 4500;
    localparam int NOM_RPT_SPACE_US  = 2250;
    localparam int NOM_BIT_MARK_US   = 560;
    localparam int NOM_SPACE0_US     = 560;
    localparam int NOM_SPACE1_US     = 1690;

    // Lower or upper edge of the accepted window around a nominal width, truncated.
    function automatic int win_bound(input int nom, input int tol_pct, input bit upper);
        if (upper) begin
            return (nom * (100 + tol_pct)) / 100;
        end
        return (nom * (100 - tol_pct)) / 100;
    endfunction

endpackage

// File: rtl/nec_ir_rx_edge_filter.sv
// rtl/nec_ir_rx_edge_filter.sv - IR input synchroniser, run-length glitch filter and edge strobes
module ir_edge_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;
    logic          sample;

    // Raw pin is active-low, so the filtered level is 1 during a mark.
    assign sample = ~sync2_q;

    // Two-flop synchroniser; resets to the idle (no mark) pin level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_raw;
            sync2_q <= sync1_q;
        end
    end

    // Level follows the sample only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sample == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT_LEN - 1)) begin
                level_q <= sample;
                cnt_q   <= '0;
                rise_q  <= sample;
                fall_q  <= ~sample;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/nec_ir_rx.sv
// rtl/nec_ir_rx.sv - NEC IR frame receiver; define NEC_REPEAT_EN to decode repeat codes
module nec_ir_rx
    import nec_ir_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int FILT_LEN   = 4,
    parameter int TOL_PCT    = 20,
    parameter int TIMEOUT_US = 12000,
    parameter int TIME_DIV   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ir_rxb,
    output logic [31:0] o_data,
    output logic [7:0]  o_cmd,
    output logic        o_valid,
    output logic        o_repeat,
    output logic        o_err,
    output logic        o_busy
);

    // TIME_DIV shrinks every nominal field width by the same factor (1 = real NEC timing).
    localparam int DIV   = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LM_LO = win_bound(NOM_LEAD_MARK_US / TIME_DIV, TOL_PCT, 1'b0);
    localparam int LM_HI = win_bound(NOM_LEAD_MARK_US / TIME_DIV, TOL_PCT, 1'b1);
    localparam int LS_LO = win_bound(NOM_LEAD_SPACE_US / TIME_DIV, TOL_PCT, 1'b0);
    localparam int LS_HI = win_bound(NOM_LEAD_SPACE_US / TIME_DIV, TOL_PCT, 1'b1);
    localparam int BM_LO = win_bound(NOM_BIT_MARK_US / TIME_DIV, TOL_PCT, 1'b0);
    localparam int BM_HI = win_bound(NOM_BIT_MARK_US / TIME_DIV, TOL_PCT, 1'b1);
    localparam int S0_LO = win_bound(NOM_SPACE0_US / TIME_DIV, TOL_PCT, 1'b0);
    localparam int S0_HI = win_bound(NOM_SPACE0_US / TIME_DIV, TOL_PCT, 1'b1);
    localparam int S1_LO = win_bound(NOM_SPACE1_US / TIME_DIV, TOL_PCT, 1'b0);
    localparam int S1_HI = win_bound(NOM_SPACE1_US / TIME_DIV, TOL_PCT, 1'b1);
`ifdef NEC_REPEAT_EN
    localparam int RS_LO = win_bound(NOM_RPT_SPACE_US / TIME_DIV, TOL_PCT, 1'b0);
    localparam int RS_HI = win_bound(NOM_RPT_SPACE_US / TIME_DIV, TOL_PCT, 1'b1);
`endif

    logic          filt_level_unused;
    logic          mark_rise;
    logic          mark_fall;
    logic [PW-1:0] pre_q;
    logic          tick;
    logic [15:0]   width_q;
    logic          timeout;
    logic [2:0]    state_q, state_d;
    logic [31:0]   shift_q, shift_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          abort;
`ifdef NEC_REPEAT_EN
    logic          rpt_q, rpt_d;
    logic          seen_q;
`endif

    function automatic logic in_win(input logic [15:0] w, input int lo, input int hi);
        int v;
        v = int'({16'd0, w});
        return (v >= lo) && (v <= hi);
    endfunction

    ir_edge_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (i_ir_rxb),
        .o_level (filt_level_unused),
        .o_rise  (mark_rise),
        .o_fall  (mark_fall)
    );

    assign tick    = (pre_q == PW'(DIV - 1));
    assign timeout = tick && (width_q == 16'(TIMEOUT_US));

    // Free-running microsecond prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Microseconds spent in the current filtered level, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q <= '0;
        end else if (mark_rise || mark_fall) begin
            width_q <= '0;
        end else if (tick && (width_q != 16'hFFFF)) begin
            width_q <= width_q + 16'd1;
        end
    end

    // Frame decoder: each filtered edge closes a field whose width is checked here.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        abort     = 1'b0;
`ifdef NEC_REPEAT_EN
        rpt_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mark_rise) state_d = LEAD_MARK;
            end
            LEAD_MARK: begin
                if (mark_fall) begin
                    if (in_win(width_q, LM_LO, LM_HI)) state_d = LEAD_SPACE;
                    else                               abort   = 1'b1;
                end
            end
            LEAD_SPACE: begin
                if (mark_rise) begin
                    if (in_win(width_q, LS_LO, LS_HI)) begin
                        state_d   = BIT_MARK;
                        bit_cnt_d = '0;
                    end
`ifdef NEC_REPEAT_EN
                    else if (in_win(width_q, RS_LO, RS_HI)) begin
                        state_d = STOP_RPT;
                    end
`endif
                    else begin
                        abort = 1'b1;
                    end
                end
            end
            BIT_MARK: begin
                if (mark_fall) begin
                    if (in_win(width_q, BM_LO, BM_HI)) state_d = BIT_SPACE;
                    else                               abort   = 1'b1;
                end
            end
            BIT_SPACE: begin
                if (mark_rise) begin
                    if (in_win(width_q, S0_LO, S0_HI) || in_win(width_q, S1_LO, S1_HI)) begin
                        shift_d[bit_cnt_q] = in_win(width_q, S1_LO, S1_HI);
                        bit_cnt_d          = bit_cnt_q + 5'd1;
                        state_d            = (bit_cnt_q == 5'd31) ? STOP : BIT_MARK;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            STOP: begin
                if (mark_fall) begin
                    if (in_win(width_q, BM_LO, BM_HI)) begin
                        state_d = IDLE;
                        if (shift_q[23:16] == ~shift_q[31:24]) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
`ifdef NEC_REPEAT_EN
            STOP_RPT: begin
                if (mark_fall) begin
                    if (in_win(width_q, BM_LO, BM_HI)) begin
                        state_d = IDLE;
                        if (seen_q) rpt_d = 1'b1;
                        else        err_d = 1'b1;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (!mark_rise && !mark_fall && (state_q != IDLE) && timeout) begin
            abort = 1'b1;
        end
        // An aborting mark_rise is also the start of a possible new frame.
        if (abort) begin
            err_d   = 1'b1;
            state_d = mark_rise ? LEAD_MARK : IDLE;
        end
    end

    // Decoder state, assembly register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

`ifdef NEC_REPEAT_EN
    // Repeat pulse, and memory of whether any frame has decoded since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q  <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            rpt_q  <= rpt_d;
            seen_q <= seen_q | valid_d;
        end
    end

    assign o_repeat = rpt_q;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_data  = data_q;
    assign o_cmd   = data_q[23:16];
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_nec_ir_rx.sv
// tb/tb_nec_ir_rx.sv - self-checking bench for nec_ir_rx (NEC_REPEAT_EN selects repeat expectations)
module tb_nec_ir_rx;

    localparam int TDIV = 20;
    localparam int TOL  = 20;
    localparam int TMO  = 600;
    localparam int GAP  = 800;
    localparam int T_LM = 9000 / TDIV;
    localparam int T_LS = 4500 / TDIV;
    localparam int T_RS = 2250 / TDIV;
    localparam int T_BM = 560 / TDIV;
    localparam int T_S0 = 560 / TDIV;
    localparam int T_S1 = 1690 / TDIV;

    typedef int dq_t[$];
    typedef struct {
        logic [31:0] frame;
        int          pct;
        int          exp_valid;
        int          exp_err;    // 0 none, 1 exactly one, 2 at least one
        logic [31:0] exp_data;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        ir;
    logic [31:0] o_data;
    logic [7:0]  o_cmd;
    logic        o_valid;
    logic        o_repeat;
    logic        o_err;
    logic        o_busy;

    int n_checks;
    int n_fail;
    int n_valid;
    int n_err;
    int n_rpt;
    int cyc;

    nec_ir_rx #(
        .CLK_HZ     (1_000_000),
        .FILT_LEN   (4),
        .TOL_PCT    (TOL),
        .TIMEOUT_US (TMO),
        .TIME_DIV   (TDIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_ir_rxb (ir),
        .o_data   (o_data),
        .o_cmd    (o_cmd),
        .o_valid  (o_valid),
        .o_repeat (o_repeat),
        .o_err    (o_err),
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (o_valid)  n_valid++;
        if (o_err)    n_err++;
        if (o_repeat) n_rpt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int win(input int nom, input bit up);
        return up ? nom * (100 + TOL) / 100 : nom * (100 - TOL) / 100;
    endfunction

    function automatic bit inw(input int meas, input int nom);
        return (meas >= win(nom, 1'b0)) && (meas <= win(nom, 1'b1));
    endfunction

    // Pulse lengths alternate mark, space, mark ... starting with the lead mark.
    function automatic dq_t build(input logic [31:0] d, input int pct);
        dq_t q;
        q.push_back(T_LM * pct / 100);
        q.push_back(T_LS * pct / 100);
        for (int i = 0; i < 32; i++) begin
            q.push_back(T_BM * pct / 100);
            q.push_back((d[i] ? T_S1 : T_S0) * pct / 100);
        end
        q.push_back(T_BM * pct / 100);
        return q;
    endfunction

    // Reference decoder over a list of pulse lengths; the width count excludes the edge cycle.
    function automatic bit ref_decode(input dq_t q, output logic [31:0] d);
        d = '0;
        if (q.size() != 67) return 1'b0;
        if (!inw(q[0] - 1, T_LM) || !inw(q[1] - 1, T_LS)) return 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (!inw(q[2 + 2 * i] - 1, T_BM)) return 1'b0;
            if (inw(q[3 + 2 * i] - 1, T_S1))      d[i] = 1'b1;
            else if (!inw(q[3 + 2 * i] - 1, T_S0)) return 1'b0;
        end
        if (!inw(q[66] - 1, T_BM)) return 1'b0;
        return d[23:16] == ~d[31:24];
    endfunction

    task automatic play(input dq_t q, input int n);
        for (int i = 0; i < n; i++) begin
            ir = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (q[i]) @(negedge clk);
        end
        ir = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vec_t        vecs[6];
        dq_t         q;
        dq_t         nomq;
        logic [31:0] exp_data;
        logic [31:0] md;
        logic [31:0] d;
        int          v0, e0, r0;
        int          t0, first, idx;
        bit          ok;

        vecs[0] = '{32'hBA45_FF00, 100, 1, 0, 32'hBA45_FF00};
        vecs[1] = '{32'hBA45_FF00, 115, 1, 0, 32'hBA45_FF00};
        vecs[2] = '{32'hBA45_FF00, 125, 0, 2, 32'hBA45_FF00};
        vecs[3] = '{32'hBB45_FF00, 100, 0, 1, 32'hBA45_FF00};
        vecs[4] = '{32'h9867_EF10,  90, 1, 0, 32'h9867_EF10};
        vecs[5] = '{32'h01FE_0807, 105, 1, 0, 32'h01FE_0807};

        n_checks = 0; n_fail = 0; n_valid = 0; n_err = 0; n_rpt = 0; cyc = 0;
        ir = 1'b1;
        rst_n = 1'b0;
        idle(3);
        check("rst_data", o_data, 32'h0);
        check("rst_cmd", {24'h0, o_cmd}, 32'h0);
        check("rst_pulses", {29'h0, o_valid, o_err, o_repeat}, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        rst_n = 1'b1;
        idle(4);
        check("post_rst_busy", {31'h0, o_busy}, 32'h0);
        exp_data = 32'h0;

        // Repeat code before any frame has decoded.
        v0 = n_valid; e0 = n_err; r0 = n_rpt;
        q = '{T_LM, T_RS, T_BM};
        play(q, 3);
        idle(GAP);
`ifdef NEC_REPEAT_EN
        check("rpt_first_err", n_err - e0, 32'd1);
`else
        check("rpt_first_err", (n_err - e0 > 0) ? 32'd1 : 32'd0, 32'd1);
`endif
        check("rpt_first_rpt", n_rpt - r0, 32'd0);
        check("rpt_first_data", o_data, exp_data);

        // Table of whole frames.
        for (int i = 0; i < 6; i++) begin
            v0 = n_valid; e0 = n_err;
            q = build(vecs[i].frame, vecs[i].pct);
            play(q, q.size());
            idle(GAP);
            check($sformatf("vec%0d_valid", i), n_valid - v0, vecs[i].exp_valid);
            if (vecs[i].exp_err == 2)
                check($sformatf("vec%0d_err", i), (n_err - e0 > 0) ? 32'd1 : 32'd0, 32'd1);
            else
                check($sformatf("vec%0d_err", i), n_err - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_data", i), o_data, vecs[i].exp_data);
            check($sformatf("vec%0d_cmd", i), {24'h0, o_cmd}, {24'h0, vecs[i].exp_data[23:16]});
            check($sformatf("vec%0d_busy", i), {31'h0, o_busy}, 32'h0);
        end
        exp_data = 32'h01FE_0807;

        // Repeat code after a good frame.
        v0 = n_valid; e0 = n_err; r0 = n_rpt;
        q = '{T_LM, T_RS, T_BM};
        play(q, 3);
        idle(GAP);
`ifdef NEC_REPEAT_EN
        check("rpt_after_rpt", n_rpt - r0, 32'd1);
        check("rpt_after_err", n_err - e0, 32'd0);
`else
        check("rpt_after_rpt", n_rpt - r0, 32'd0);
        check("rpt_after_err", (n_err - e0 > 0) ? 32'd1 : 32'd0, 32'd1);
`endif
        check("rpt_after_data", o_data, exp_data);

        // Lead plus ten bit marks, then the line stays idle until the timeout.
        e0 = n_err;
        q = build(32'hBA45_FF00, 100);
        play(q, 21);
        t0 = cyc;
        first = -1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (o_err && first < 0) first = cyc - t0;
        end
        check("tmo_count", n_err - e0, 32'd1);
        check("tmo_when", (first >= 603 && first <= 613) ? 32'd1 : 32'd0, 32'd1);
        check("tmo_busy", {31'h0, o_busy}, 32'h0);
        check("tmo_data", o_data, exp_data);

        // Three-cycle space glitch inside the lead mark.
        v0 = n_valid; e0 = n_err;
        q = build(32'hE21D_7B84, 100);
        q.delete(0);
        q.push_front(T_LM - 3 - T_LM / 2);
        q.push_front(3);
        q.push_front(T_LM / 2);
        play(q, q.size());
        idle(GAP);
        check("glitch_valid", n_valid - v0, 32'd1);
        check("glitch_err", n_err - e0, 32'd0);
        check("glitch_data", o_data, 32'hE21D_7B84);
        exp_data = 32'hE21D_7B84;

        // Asynchronous reset at bit 20, then a clean frame.
        q = build(32'h7F80_DF20, 100);
        play(q, 42);
        check("mid_busy", {31'h0, o_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, o_busy}, 32'h0);
        check("mid_rst_data", o_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_data = 32'h0;
        idle(GAP);
        v0 = n_valid;
        play(q, q.size());
        idle(GAP);
        check("after_rst_valid", n_valid - v0, 32'd1);
        check("after_rst_data", o_data, 32'h7F80_DF20);
        exp_data = 32'h7F80_DF20;

        // Randomised frames: jittered fields, sometimes one badly wrong field or a bad ~cmd.
        for (int k = 0; k < 6; k++) begin
            d = $urandom;
            if ($urandom_range(0, 3) != 0) d[31:24] = ~d[23:16];
            nomq = build(d, 100);
            q = nomq;
            for (int i = 0; i < q.size(); i++) q[i] = nomq[i] * $urandom_range(90, 110) / 100;
            if ($urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, 66);
                q[idx] = nomq[idx] * (($urandom_range(0, 1) == 1) ? 135 : 65) / 100;
            end
            ok = ref_decode(q, md);
            if (ok) exp_data = md;
            v0 = n_valid; e0 = n_err;
            play(q, q.size());
            idle(GAP);
            check($sformatf("rnd%0d_valid", k), n_valid - v0, ok ? 32'd1 : 32'd0);
            check($sformatf("rnd%0d_err", k), (n_err - e0 > 0) ? 32'd1 : 32'd0, ok ? 32'd0 : 32'd1);
            check($sformatf("rnd%0d_data", k), o_data, exp_data);
        end

        $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
        $finish;
    end

endmodule
